// File: rtl/flash_read_ctrl_pkg.sv
// Shared definitions for the NOR flash read path: load opcodes, controller
// states and the read-array command word.
package flash_pkg;

   typedef enum logic [2:0] {
      OP_LB  = 3'd0,
      OP_LBU = 3'd1,
      OP_LH  = 3'd2,
      OP_LHU = 3'd3,
      OP_LW  = 3'd4
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD_WE,
      S_CMD_HOLD,
      S_RD,
      S_GAP,
      S_DONE
   } state_e;

   localparam logic [15:0] FLASH_CMD_READ_ARRAY = 16'h00FF;

   // Encodings above LW have no meaning of their own and are folded onto LW.
   function automatic op_e norm_op(input logic [2:0] op);
      return (op > 3'd4) ? OP_LW : op_e'(op);
   endfunction

endpackage

// File: rtl/flash_load_extend.sv
// Picks the byte or halfword out of the assembled {beat1, beat0} word and
// applies sign or zero extension for the load type.
module flash_load_extend
   import flash_pkg::*;
(
   input  logic [31:0] i_beats,
   input  op_e         i_op,
   input  logic        i_byte_sel,
   output logic [31:0] o_data
);

   logic [7:0] w_byte;

   always_comb begin
      w_byte = i_byte_sel ? i_beats[15:8] : i_beats[7:0];
      case (i_op)
         OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
         OP_LBU:  o_data = {24'd0, w_byte};
         OP_LH:   o_data = {{16{i_beats[15]}}, i_beats[15:0]};
         OP_LHU:  o_data = {16'd0, i_beats[15:0]};
         default: o_data = i_beats;
      endcase
   end

endmodule

// File: rtl/flash_read_ctrl.sv
// Load controller for the 16-bit NOR flash: optional read-array command,
// one or two read beats, then a single-cycle completion strobe.
module flash_read_ctrl
   import flash_pkg::*;
#(
   parameter int          ADDR_W = 23,
   parameter int          RD_CYC = 4,
   parameter int          WE_CYC = 2,
   parameter logic [31:0] BASE   = 32'h8000_0000,
   parameter logic [31:0] SIZE   = 32'h0040_0000
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_i,
   input  logic [31:0]       addr_i,
   input  logic [2:0]        op_i,
   input  logic              inval_i,
   output logic [31:0]       rdata_o,
   output logic              done_o,
   output logic              pause_o,
   output logic              err_o,
   output logic [ADDR_W-1:0] flash_a_o,
   output logic [15:0]       flash_d_o,
   output logic              flash_d_oe_o,
   input  logic [15:0]       flash_d_i,
   output logic              flash_ce_n_o,
   output logic              flash_we_n_o,
   output logic              flash_oe_n_o
);

   localparam int CNT_MAX = (RD_CYC > WE_CYC) ? RD_CYC : WE_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_e            r_state, w_state_next;
   logic [CNT_W-1:0]  r_cnt, w_cnt_next;
   op_e               r_op;
   logic              r_byte_sel;
   logic [ADDR_W-1:0] r_hw_addr, w_hw_next;
   logic              r_beat, w_beat_next;
   logic [31:0]       r_data;
   logic              r_array_mode;
   logic              r_ce_n, r_we_n, r_oe_n, r_d_oe;
   logic [15:0]       r_d;
   logic [ADDR_W-1:0] r_a;

   logic [31:0]       w_offset;
   op_e               w_op;
   logic              w_misal, w_legal, w_accept, w_rd_last, w_bus_next;
   logic [31:0]       w_ext;

   assign w_offset  = addr_i - BASE;
   assign w_op      = norm_op(op_i);
   assign w_misal   = (((w_op == OP_LH) || (w_op == OP_LHU)) && addr_i[0]) ||
                      ((w_op == OP_LW) && (addr_i[1:0] != 2'b00));
   // Wrapping subtraction makes addresses below BASE look huge, so one compare covers both ends.
   assign w_legal   = !w_misal && (w_offset < SIZE);
   assign w_accept  = (r_state == S_IDLE) && req_i && w_legal;
   assign w_rd_last = (r_cnt == CNT_W'(RD_CYC - 1));

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = '0;
      w_hw_next    = r_hw_addr;
      w_beat_next  = r_beat;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_next = r_array_mode ? S_RD : S_CMD_WE;
               w_hw_next    = w_offset[ADDR_W:1];
               w_beat_next  = 1'b0;
            end
         end
         S_CMD_WE: begin
            if (r_cnt == CNT_W'(WE_CYC - 1)) w_state_next = S_CMD_HOLD;
            else                             w_cnt_next   = r_cnt + 1'b1;
         end
         S_CMD_HOLD: w_state_next = S_RD;
         S_RD: begin
            if (w_rd_last) w_state_next = ((r_op == OP_LW) && !r_beat) ? S_GAP : S_DONE;
            else           w_cnt_next   = r_cnt + 1'b1;
         end
         S_GAP: begin
            w_state_next = S_RD;
            w_beat_next  = 1'b1;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign w_bus_next = (w_state_next == S_CMD_WE) || (w_state_next == S_CMD_HOLD) ||
                       (w_state_next == S_RD)     || (w_state_next == S_GAP);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_op         <= OP_LW;
         r_byte_sel   <= 1'b0;
         r_hw_addr    <= '0;
         r_beat       <= 1'b0;
         r_data       <= '0;
         r_array_mode <= 1'b0;
         r_ce_n       <= 1'b1;
         r_we_n       <= 1'b1;
         r_oe_n       <= 1'b1;
         r_d_oe       <= 1'b0;
         r_d          <= '0;
         r_a          <= '0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_hw_addr <= w_hw_next;
         r_beat    <= w_beat_next;
         if (w_accept) begin
            r_op       <= w_op;
            r_byte_sel <= addr_i[0];
         end
         if ((r_state == S_RD) && w_rd_last) begin
            if (r_beat) r_data[31:16] <= flash_d_i;
            else        r_data[15:0]  <= flash_d_i;
         end
         // An invalidate wins over a command finishing in the same cycle.
         if (inval_i)                     r_array_mode <= 1'b0;
         else if (r_state == S_CMD_HOLD)  r_array_mode <= 1'b1;
         // Pins are registered from the next state so they switch cleanly on state entry.
         r_ce_n <= !w_bus_next;
         r_we_n <= (w_state_next != S_CMD_WE);
         r_oe_n <= (w_state_next != S_RD);
         r_d_oe <= (w_state_next == S_CMD_WE) || (w_state_next == S_CMD_HOLD);
         r_d    <= ((w_state_next == S_CMD_WE) || (w_state_next == S_CMD_HOLD)) ?
                   FLASH_CMD_READ_ARRAY : 16'h0000;
         r_a    <= w_bus_next ? {w_hw_next[ADDR_W-1:1], w_hw_next[0] | w_beat_next} : '0;
      end
   end

   flash_load_extend u_extend (
      .i_beats    (r_data),
      .i_op       (r_op),
      .i_byte_sel (r_byte_sel),
      .o_data     (w_ext)
   );

   assign done_o       = (r_state == S_DONE);
   assign rdata_o      = done_o ? w_ext : 32'd0;
   assign err_o        = (r_state == S_IDLE) && req_i && !w_legal;
   assign pause_o      = w_accept || (r_state == S_CMD_WE) || (r_state == S_CMD_HOLD) ||
                         (r_state == S_RD) || (r_state == S_GAP);
   assign flash_a_o    = r_a;
   assign flash_d_o    = r_d;
   assign flash_d_oe_o = r_d_oe;
   assign flash_ce_n_o = r_ce_n;
   assign flash_we_n_o = r_we_n;
   assign flash_oe_n_o = r_oe_n;

endmodule

// File: doc/flash_read_ctrl.md
# flash_read_ctrl

Parametrised read controller for the 16-bit NOR flash on the board's external bus, sitting between the MEM stage and the flash pins. Accepts byte, halfword and word loads inside a configurable address window and issues the read-array command (0x00FF) only when the device is not already known to be in array mode. Assembles 32-bit words from two halfword beats, applies sign/zero extension and stalls the pipeline until data is ready. Adds programmable access timing and misalignment and window-miss flags.

## Interface
- ADDR_W, 23: flash halfword-address width.
- RD_CYC, 4: cycles `flash_oe_n_o` is held low per beat (≥1); data is sampled on the last of them.
- WE_CYC, 2: cycles `flash_we_n_o` is held low for the command write (≥1).
- BASE, 32'h8000_0000: first byte address of the flash window.
- SIZE, 32'h0040_0000: window size in bytes (power of two, ≤ 2^(ADDR_W+1)).
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_i  in  1  load request; held with addr_i/op_i stable until `done_o`.
- addr_i  in  32  byte address.
- op_i  in  3  load type (LB, LBU, LH, LHU, LW).
- inval_i  in  1  one-cycle pulse: device may have left array mode (after program/erase); clears `array_mode`.
- rdata_o  out  32  extended load data; valid only while `done_o`=1, otherwise 0.
- done_o  out  1  one-cycle completion strobe.
- pause_o  out  1  stall request to the pipeline.
- err_o  out  1  one-cycle strobe: misaligned or out-of-window request, no bus access.
- flash_a_o  out  ADDR_W  halfword address.
- flash_d_o  out  16  write data; flash_d_oe_o  out  1  data-bus drive enable; flash_d_i  in  16  read data.
- flash_ce_n_o, flash_we_n_o, flash_oe_n_o  out  1 each  active-low chip, write and output enables.

## Operation
- Reset values: every `*_n_o`=1, flash_d_oe_o=0, flash_d_o=0, flash_a_o=0, rdata_o=0, done_o=0, pause_o=0, err_o=0; state IDLE; array_mode=0.
- Accept: in IDLE with req_i=1. Request is illegal if LH/LHU and addr_i[0]≠0, if LW and addr_i[1:0]≠0, or if addr_i is outside [BASE, BASE+SIZE). Illegal → err_o=1 for one cycle, stay in IDLE, pause_o=0. Unknown op_i → treated as LW.
- Offset = addr_i−BASE; beat address = offset[ADDR_W:1]; for LW, beat k (k=0,1) uses {offset[ADDR_W:2], k}. Beat 0 is the low halfword.
- States:
  - IDLE
  - CMD_WE: ce_n=0, we_n=0, d_oe=1, d_o=16'h00FF, WE_CYC cycles.
  - CMD_HOLD: we_n=1, ce_n=0, data still driven, 1 cycle; sets array_mode.
  - RD: ce_n=0, oe_n=0, d_oe=0, RD_CYC cycles; captures flash_d_i on the last cycle.
  - GAP: oe_n=1, ce_n=0, 1 cycle, between LW beats only.
  - DONE: all pins idle, done_o=1, 1 cycle, then IDLE.
- From IDLE a legal request goes to CMD_WE if array_mode=0, otherwise to RD.
- Extension: LB/LBU select byte addr_i[0] (0 = d[7:0]) with sign or zero extension; LH/LHU extend the halfword; LW = {beat1, beat0}.
- pause_o = (IDLE & legal req_i) | state∈{CMD_WE, CMD_HOLD, RD, GAP}. It is 0 in DONE so the pipeline advances. req_i seen in DONE is ignored.
- inval_i takes effect on the next edge in any state. An access already in progress completes unchanged; the next request reissues the command.
- rst mid-access aborts: pins return to idle values on the next edge. No done_o or err_o is produced.

## Timing
- Request accepted at cycle t with array_mode=1: RD occupies t+1..t+RD_CYC; DONE at t+RD_CYC+1 for byte/half loads.
- LW: beat 0 at t+1..t+RD_CYC, GAP at t+RD_CYC+1, beat 1 at t+RD_CYC+2..t+2·RD_CYC+1, DONE at t+2·RD_CYC+2.
- With array_mode=0, add WE_CYC+1 cycles before the first RD.
- All pin outputs are registered from the state and counter; none depend combinationally on req_i.

## Structure
- Package flash_pkg: op encodings (LB=0, LBU=1, LH=2, LHU=3, LW=4), the state enum and FLASH_CMD_READ_ARRAY=16'h00FF.
- Sub-module flash_load_extend: combinational byte/half selection and extension from {beat1, beat0}, op and addr[0]. The counter and FSM stay in flash_read_ctrl.

## Test plan
- Cold LH at 0x8000_0010, flash word 0x8001, RD_CYC=4, WE_CYC=2 → one 00FF write, flash_a_o=0x8, done_o at t+8, rdata_o=0xFFFF_8001.
- Following LBU at 0x8000_0011 with the same data → no command, done_o at t+5, rdata_o=0x0000_0080.
- LW at 0x8000_0100, halves 0x1234 and 0xABCD → addresses 0x80 then 0x81, one GAP cycle, rdata_o=0xABCD_1234 at t+10.
- LW at 0x8000_0102, and LB at 0x8040_0000 → err_o for 1 cycle, no ce_n activity, pause_o=0.
- inval_i pulse then LH → 00FF command reissued; rst asserted during RD → next cycle all pins idle, no done_o.
